// File: rtl/life_gen_scheduler.sv
// Launches one life-update pass every FRAMES_PER_GEN frames or per step request; swaps buffers at vblank start.
// Launch/swap visible one clk after the qualifying frame tick; no backpressure, a due generation hitting a busy engine is dropped and flagged.
module life_gen_scheduler #(
    parameter int HPIXEL         = 640,
    parameter int VPIXEL         = 480,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] hCount,
    input  logic [11:0] vCount,
    input  logic        run,
    input  logic        step,
    input  logic        genDone,
    input  logic        clearOverrun,
    output logic        genStart,
    output logic        dispBuf,
    output logic [15:0] generation,
    output logic        busy,
    output logic        overrun
);

    localparam int FCW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_READY
    } state_t;

    state_t         state_q, state_d;
    logic           cond_q, cond_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           step_pending_q, step_pending_d;
    logic           gen_start_q, gen_start_d;
    logic           disp_buf_q, disp_buf_d;
    logic [15:0]    generation_q, generation_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;

    logic frame_tick, auto_due, due, launch, swap;

    always_comb begin
        // Raster may hold the vblank origin for several clks; only its first clk is the tick.
        cond_d     = (vCount == 12'(VPIXEL)) && (hCount == 12'd0);
        frame_tick = cond_d && !cond_q;
        auto_due   = run && frame_tick && (frame_cnt_q == FC_LAST);
        due        = auto_due || (frame_tick && step_pending_q);

        state_d = state_q;
        launch  = 1'b0;
        swap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (due) begin
                    state_d = ST_START;
                    launch  = 1'b1;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (genDone) begin
                    if (frame_tick) begin
                        swap    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (frame_tick) begin
                    swap    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        frame_cnt_d = frame_cnt_q;
        if (!run) begin
            frame_cnt_d = '0;
        end else if (frame_tick) begin
            frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + 1'b1;
        end

        // A step arriving on the launch cycle is served by that launch.
        step_pending_d = step_pending_q;
        if (launch) begin
            step_pending_d = 1'b0;
        end else if (step) begin
            step_pending_d = 1'b1;
        end

        disp_buf_d   = swap ? ~disp_buf_q : disp_buf_q;
        generation_d = swap ? generation_q + 16'd1 : generation_q;

        overrun_d = overrun_q;
        if (auto_due && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (clearOverrun) begin
            overrun_d = 1'b0;
        end

        gen_start_d = (state_d == ST_START);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cond_q         <= 1'b0;
            frame_cnt_q    <= '0;
            step_pending_q <= 1'b0;
            gen_start_q    <= 1'b0;
            disp_buf_q     <= 1'b0;
            generation_q   <= 16'd0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cond_q         <= cond_d;
            frame_cnt_q    <= frame_cnt_d;
            step_pending_q <= step_pending_d;
            gen_start_q    <= gen_start_d;
            disp_buf_q     <= disp_buf_d;
            generation_q   <= generation_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign genStart   = gen_start_q;
    assign dispBuf    = disp_buf_q;
    assign generation = generation_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

    // The tick sits at the line origin, which must lie inside the visible line width.
    a_tick_on_line: assert property (@(posedge clk) disable iff (!rst_n)
        frame_tick |-> (hCount < 12'(HPIXEL)));

endmodule

// File: tb/tb_life_gen_scheduler.sv
module tb_life_gen_scheduler;

    localparam int HP  = 16;
    localparam int VP  = 8;
    localparam int FPG = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] hCount, vCount;
    logic        run, step, genDone, clearOverrun;
    logic        genStart, dispBuf, busy, overrun;
    logic [15:0] generation;

    int checks = 0;
    int errors = 0;
    int gs_cnt = 0;
    int gs_base;

    life_gen_scheduler #(.HPIXEL(HP), .VPIXEL(VP), .FRAMES_PER_GEN(FPG)) dut (
        .clk(clk), .rst_n(rst_n), .hCount(hCount), .vCount(vCount),
        .run(run), .step(step), .genDone(genDone), .clearOverrun(clearOverrun),
        .genStart(genStart), .dispBuf(dispBuf), .generation(generation),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (genStart === 1'b1) gs_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // First cycle keeps the raster at the vblank origin, so every tick holds cond for two clks.
    task automatic idle(input int n);
        cyc();
        vCount = 12'd3;
        hCount = 12'd7;
        repeat (n - 1) cyc();
    endtask

    task automatic tick();
        vCount = 12'(VP);
        hCount = 12'd0;
        cyc();
    endtask

    task automatic frame();
        tick();
        idle(40);
    endtask

    task automatic pulse_done();
        genDone = 1'b1;
        cyc();
        genDone = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; genDone = 1'b0; clearOverrun = 1'b0;
        vCount = 12'd3; hCount = 12'd7;

        // Reset and idle
        repeat (3) cyc();
        chk("rst_genStart", genStart, 0);
        chk("rst_dispBuf", dispBuf, 0);
        chk("rst_generation", generation, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        cyc();
        repeat (3) frame();
        chk("idle_no_start", gs_cnt, 0);
        chk("idle_busy", busy, 0);

        // Auto cadence, every second frame
        run = 1'b1;
        frame();
        for (int g = 1; g <= 3; g++) begin
            tick();
            chk("auto_genStart", genStart, 1);
            chk("auto_busy", busy, 1);
            idle(20);
            pulse_done();
            chk("auto_wait_swap", generation, g - 1);
            idle(20);
            tick();
            chk("auto_generation", generation, g);
            chk("auto_dispBuf", dispBuf, g % 2);
            chk("auto_idle", busy, 0);
            idle(40);
        end
        chk("auto_starts", gs_cnt, 3);
        chk("auto_overrun", overrun, 0);
        run = 1'b0;

        // Single step
        idle(10);
        pulse_step();
        chk("step_no_immediate", genStart, 0);
        idle(10);
        tick();
        chk("step_genStart", genStart, 1);
        idle(20);
        pulse_done();
        idle(20);
        tick();
        chk("step_generation", generation, 4);
        chk("step_dispBuf", dispBuf, 0);
        gs_base = gs_cnt;
        repeat (4) frame();
        chk("step_no_more", gs_cnt, gs_base);

        // genDone in START ignored; then coincident done and tick
        pulse_step();
        idle(10);
        tick();
        chk("coin_genStart", genStart, 1);
        genDone = 1'b1;
        cyc();
        genDone = 1'b0;
        idle(40);
        tick();
        chk("start_done_ignored_busy", busy, 1);
        chk("start_done_ignored_gen", generation, 4);
        idle(40);
        genDone = 1'b1;
        tick();
        genDone = 1'b0;
        chk("coin_dispBuf", dispBuf, 1);
        chk("coin_generation", generation, 5);
        chk("coin_busy", busy, 0);
        gs_base = gs_cnt;
        frame();
        chk("coin_no_launch", gs_cnt, gs_base);

        // Overrun
        run = 1'b1;
        gs_base = gs_cnt;
        frame();
        tick();
        chk("ovr_genStart", genStart, 1);
        idle(40);
        frame();
        tick();
        chk("ovr_set", overrun, 1);
        chk("ovr_no_restart", genStart, 0);
        idle(40);
        frame();
        clearOverrun = 1'b1;
        tick();
        clearOverrun = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        chk("ovr_single_start", gs_cnt, gs_base + 1);
        idle(10);
        clearOverrun = 1'b1;
        cyc();
        clearOverrun = 1'b0;
        chk("ovr_cleared", overrun, 0);
        pulse_done();
        idle(20);
        tick();
        chk("ovr_generation", generation, 6);
        chk("ovr_dispBuf", dispBuf, 0);
        run = 1'b0;
        idle(40);

        // Reset mid-pass
        pulse_step();
        idle(10);
        tick();
        idle(10);
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_genStart", genStart, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_generation", generation, 0);
        chk("mid_rst_dispBuf", dispBuf, 0);
        chk("mid_rst_overrun", overrun, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        pulse_done();
        idle(10);
        chk("mid_done_ignored", busy, 0);
        gs_base = gs_cnt;
        frame();
        frame();
        chk("mid_no_launch", gs_cnt, gs_base);
        chk("mid_generation", generation, 0);
        pulse_step();
        idle(10);
        tick();
        chk("mid_fresh_launch", genStart, 1);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
